// File: rtl/vector_reader.sv
// vector_reader: pops programmed-length bursts from a fall-through FIFO into a 2-entry skid buffer feeding a valid/ready stream
module vector_reader #(
  parameter int WIDTH = 248,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fifo_read,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready,
  output logic [LEN_W-1:0] o_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       state;
  logic [LEN_W-1:0] rem_f, rem_a;
  logic [1:0]       occ, wptr;
  logic [WIDTH-1:0] d0, d1;
  logic             l0, l1, push, pop, fin, tail_last;
  assign o_valid     = occ != 2'd0;
  assign o_data      = d0;
  assign o_last      = o_valid & l0;
  assign o_count     = rem_a;
  assign o_busy      = state != IDLE;
  assign o_done      = state == DONE;
  assign o_fifo_read = (state == FETCH) & ~i_fifo_empty & (rem_f != '0) & (occ != 2'd2);
  assign push        = o_fifo_read;
  assign pop         = o_valid & i_ready;
  assign fin         = pop & l0;
  assign tail_last   = rem_f == LEN_W'(1);
  // Tail slot accounts for a same-cycle pop shifting the head forward
  assign wptr        = occ - {1'b0, pop};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem_f <= '0;
      rem_a <= '0;
    end else begin
      if (pop) rem_a <= rem_a - 1'b1;
      if (push) rem_f <= rem_f - 1'b1;
      case (state)
        IDLE: if (i_start) begin
          rem_f <= i_len;
          rem_a <= i_len;
          state <= (i_len == '0) ? DONE : FETCH;
        end
        FETCH: state <= fin ? DONE : (push & tail_last) ? FLUSH : FETCH;
        FLUSH: state <= fin ? DONE : FLUSH;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      if (push && wptr == 2'd0) begin
        d0 <= i_fifo_data;
        l0 <= tail_last;
      end
      if (push && wptr == 2'd1) begin
        d1 <= i_fifo_data;
        l1 <= tail_last;
      end
    end
  end
endmodule

// File: tb/tb_vector_reader.sv
// tb_vector_reader: directed scenarios plus random traffic checked against a count-based burst model
module tb_vector_reader;
  localparam int W  = 248;
  localparam int LW = 8;
  logic          clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_ready = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic          i_fifo_empty;
  logic [W-1:0]  i_fifo_data;
  logic          o_busy, o_done, o_fifo_read, o_valid, o_last;
  logic [W-1:0]  o_data;
  logic [LW-1:0] o_count;
  logic [W-1:0]  pushed [2048];
  int np = 0, tp = 0;
  int n_cmp = 0, n_bad = 0;
  int ph = 0, m_len = 0, m_acc = 0, m_pops = 0, base = 0, n_done = 0, n_xfer = 0;
  int pin_go = 0, pin_seen = 0, pin_act = 0, pin_exp = 0;
  string pin_name = "";
  bit rnd = 1'b0;

  assign i_fifo_empty = tp >= np;
  assign i_fifo_data  = (tp < np) ? pushed[tp] : '0;

  always #5 clk = ~clk;

  vector_reader #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .o_fifo_read(o_fifo_read), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready), .o_count(o_count)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a burst is just (len, words popped, words accepted); the FIFO is the pushed array read in order
  always begin : cmp
    int occ, nph, nlen, nacc, npops, nbase, ntp;
    bit ev, erd;
    @(negedge clk);
    if (pin_go != pin_seen) begin
      pin_seen = pin_go;
      chk(pin_name, W'(pin_act), W'(pin_exp));
    end
    nph = ph; nlen = m_len; nacc = m_acc; npops = m_pops; nbase = base;
    ntp = tp + (o_fifo_read ? 1 : 0);
    if (rst) begin
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_read", o_fifo_read, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_last", o_last, 0);
      chk("rst_count", o_count, 0);
      chk("rst_data", o_data, 0);
      nph = 0; nlen = 0; nacc = 0; npops = 0;
    end else begin
      occ = (ph == 1) ? m_pops - m_acc : 0;
      ev  = occ > 0;
      erd = ph == 1 && !i_fifo_empty && m_pops < m_len && occ < 2;
      chk("busy", o_busy, ph != 0);
      chk("done", o_done, ph == 2);
      chk("fifo_read", o_fifo_read, erd);
      chk("valid", o_valid, ev);
      chk("count", o_count, (ph == 1) ? W'(m_len - m_acc) : '0);
      chk("last", o_last, ev && m_acc == m_len - 1);
      if (ev) chk("data", o_data, pushed[base + m_acc]);
      if (ph == 0 && i_start) begin
        nph = (i_len == 0) ? 2 : 1;
        nlen = int'(i_len); nacc = 0; npops = 0; nbase = tp;
      end else if (ph == 1) begin
        if (erd) npops++;
        if (ev && i_ready) begin
          nacc++;
          n_xfer++;
          if (nacc == m_len) nph = 2;
        end
      end else if (ph == 2) begin
        nph = 0;
        n_done++;
      end
    end
    @(posedge clk);
    #1;
    ph = nph; m_len = nlen; m_acc = nacc; m_pops = npops; base = nbase; tp = ntp;
  end

  function automatic logic [W-1:0] rw();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      pushed[np] = rw();
      np++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rnd) begin
      i_ready = $urandom_range(0, 3) != 0;
      if (np < 2000 && $urandom_range(0, 2) == 0) push(1);
      i_start = $urandom_range(0, 5) == 0;
      i_len   = LW'($urandom_range(0, 10));
    end
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    pin_name = nm; pin_act = act; pin_exp = exp;
    pin_go++;
    cyc();
  endtask

  task automatic start(input int len);
    i_start = 1'b1;
    i_len   = LW'(len);
    cyc();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    pin({nm, "_done_seen"}, int'(ok), 1);
  endtask

  initial begin
    int t0, x0, d0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    // preloaded 4-word burst at full rate
    push(4); i_ready = 1'b1; t0 = tp; x0 = n_xfer; d0 = n_done;
    start(4);
    pin("t1_first_read", int'(o_fifo_read), 1);
    pin("t1_valid_latency", int'(o_valid), 1);
    wait_done("t1");
    pin("t1_busy_after", int'(o_busy), 0);
    pin("t1_pops", tp - t0, 4);
    pin("t1_xfers", n_xfer - x0, 4);
    pin("t1_dones", n_done - d0, 1);
    // consumer stalled: buffer fills to two and fetching stops
    push(6); i_ready = 1'b0; t0 = tp;
    start(6);
    repeat (4) cyc();
    pin("t2_pops_stalled", tp - t0, 2);
    i_ready = 1'b1;
    wait_done("t2");
    pin("t2_pops", tp - t0, 6);
    // FIFO runs dry mid-burst
    push(1); t0 = tp;
    start(3);
    repeat (4) cyc();
    pin("t3_pops_stalled", tp - t0, 1);
    push(2);
    wait_done("t3");
    pin("t3_pops", tp - t0, 3);
    // null burst
    t0 = tp; x0 = n_xfer; d0 = n_done;
    start(0);
    pin("t4_busy", int'(o_busy), 1);
    pin("t4_idle", int'(o_busy), 0);
    pin("t4_pops", tp - t0, 0);
    pin("t4_xfers", n_xfer - x0, 0);
    pin("t4_dones", n_done - d0, 1);
    // reset abandons a burst with two words buffered
    push(5); i_ready = 1'b0; t0 = tp;
    start(5);
    repeat (3) cyc();
    pin("t5_pops_before_rst", tp - t0, 2);
    #1 rst = 1'b1;
    cyc();
    cyc();
    #1 rst = 1'b0;
    cyc();
    i_ready = 1'b1; t0 = tp; x0 = n_xfer;
    start(2);
    wait_done("t5");
    pin("t5_pops_fresh", tp - t0, 2);
    pin("t5_xfers_fresh", n_xfer - x0, 2);
    // start while busy is ignored
    push(4); t0 = tp; x0 = n_xfer; d0 = n_done;
    start(4);
    i_start = 1'b1; i_len = 8'd9;
    cyc();
    i_start = 1'b0;
    wait_done("t6");
    pin("t6_pops", tp - t0, 4);
    pin("t6_xfers", n_xfer - x0, 4);
    pin("t6_dones", n_done - d0, 1);
    // longest burst the counters allow
    push(255); x0 = n_xfer;
    start(255);
    pin("tmax_count", int'(o_count), 255);
    wait_done("tmax");
    pin("tmax_xfers", n_xfer - x0, 255);
    // random traffic
    d0 = n_done;
    rnd = 1'b1;
    repeat (3000) cyc();
    rnd = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    push(12);
    for (int i = 0; i < 200 && o_busy; i++) cyc();
    pin("rnd_idle", int'(o_busy), 0);
    pin("rnd_many_bursts", int'(n_done - d0 > 50), 1);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
